// File: rtl/nios2_onchip_mem_dp_if.sv
// rtl/nios2_onchip_mem_dp_if.sv - one Avalon-style slave port of the dual-port on-chip memory

interface nios2_onchip_mem_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
) ();
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [BE_WIDTH-1:0]   byteenable;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/nios2_onchip_mem_dp.sv
// rtl/nios2_onchip_mem_dp.sv - true dual-port on-chip RAM with byte lanes, 1/2-cycle read latency

module nios2_onchip_mem_dp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int DEPTH        = 5120,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "nios2_onchip_mem_dp.hex"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    nios2_onchip_mem_dp_if.slave  s1,
    nios2_onchip_mem_dp_if.slave  s2,
    output logic                  range_err
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [BE_WIDTH-1:0]   be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic [1:0] cs, rd, wr, in_range, acc_rd, acc_wr, oob, rvalid;

    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;
    assign cs       = {s2.chipselect, s1.chipselect};
    assign rd       = {s2.read, s1.read};
    assign wr       = {s2.write, s1.write};

    assign s1.readdata      = rdata[0];
    assign s2.readdata      = rdata[1];
    assign s1.readdatavalid = rvalid[0];
    assign s2.readdatavalid = rvalid[1];

    // Write wins over read; out-of-range reads still return a (zero) beat.
    assign acc_rd = cs & rd & ~wr;
    assign acc_wr = cs & wr & in_range;
    assign oob    = cs & (rd | wr) & ~in_range;

    // s2 lanes are applied first so s1 overrides any lane both ports enable.
    always_ff @(posedge clk) begin
        if (clken && !reset) begin
            for (int p = 1; p >= 0; p--) begin
                if (acc_wr[p]) begin
                    for (int i = 0; i < BE_WIDTH; i++) begin
                        if (be[p][i]) begin
                            mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  v0;
        logic [DATA_WIDTH-1:0] d0;

        assign in_range[p] = {1'b0, addr[p]} < DEPTH_W;

        // Non-blocking read of mem yields pre-write data on a same-cycle write.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v0 <= 1'b0;
                d0 <= '0;
            end else if (clken) begin
                v0 <= acc_rd[p];
                if (acc_rd[p]) begin
                    d0 <= in_range[p] ? mem[addr[p]] : '0;
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  v1;
            logic [DATA_WIDTH-1:0] d1;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v1 <= 1'b0;
                    d1 <= '0;
                end else if (clken) begin
                    v1 <= v0;
                    if (v0) begin
                        d1 <= d0;
                    end
                end
            end

            assign rvalid[p] = v1;
            assign rdata[p]  = d1;
        end else begin : g_lat1
            assign rvalid[p] = v0;
            assign rdata[p]  = d0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            range_err <= 1'b0;
        end else if (clken && (|oob)) begin
            range_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nios2_onchip_mem_dp.sv
// tb/tb_nios2_onchip_mem_dp.sv - scoreboard bench for both read latencies side by side

module tb_nios2_onchip_mem_dp;
    localparam int DW    = 32;
    localparam int AW    = 13;
    localparam int DEPTH = 5120;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clken = 1'b1;
    logic ra, rb;

    always #5 clk = ~clk;

    nios2_onchip_mem_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
    nios2_onchip_mem_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a2 ();
    nios2_onchip_mem_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
    nios2_onchip_mem_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

    nios2_onchip_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                          .READ_LATENCY(1), .INIT_FILE("")) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .s1(a1), .s2(a2), .range_err(ra));

    nios2_onchip_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                          .READ_LATENCY(2), .INIT_FILE("")) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .s1(b1), .s2(b2), .range_err(rb));

    int tests = 0;
    int fails = 0;
    int ecyc = 0;
    bit en_edge = 1'b0;
    int range_due = 32'h7fffffff;

    logic [31:0] model [0:DEPTH-1];
    logic [63:0] q [4][$];
    logic [31:0] last [4];
    logic [31:0] rd_m [4];
    logic        rv_m [4];

    assign rd_m[0] = a1.readdata;  assign rv_m[0] = a1.readdatavalid;
    assign rd_m[1] = a2.readdata;  assign rv_m[1] = a2.readdatavalid;
    assign rd_m[2] = b1.readdata;  assign rv_m[2] = b1.readdatavalid;
    assign rd_m[3] = b2.readdata;  assign rv_m[3] = b2.readdatavalid;

    logic [1:0]  s_cs, s_rd, s_wr;
    logic [12:0] s_ad [2];
    logic [3:0]  s_be [2];
    logic [31:0] s_wd [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at enabled cycle %0d", name, act, exp, ecyc);
        end
    endtask

    always @(posedge clk) begin
        en_edge = clken && !reset;
        if (en_edge) ecyc++;
    end

    // Monitor: only judges outputs produced by an enabled, non-reset edge.
    always @(negedge clk) begin
        if (en_edge && !reset) begin
            for (int k = 0; k < 4; k++) begin
                logic [63:0] e;
                if (rv_m[k]) begin
                    if (q[k].size() == 0) begin
                        check($sformatf("spurious_valid[%0d]", k), {31'b0, rv_m[k]}, 32'd0);
                    end else begin
                        e = q[k].pop_front();
                        check($sformatf("rdata[%0d]", k), rd_m[k], e[31:0]);
                        check($sformatf("latency[%0d]", k), ecyc, e[63:32]);
                        last[k] = e[31:0];
                    end
                end else begin
                    check($sformatf("hold[%0d]", k), rd_m[k], last[k]);
                    if (q[k].size() != 0 && int'(q[k][0][63:32]) <= ecyc) begin
                        check($sformatf("missing_valid[%0d]", k), {31'b0, rv_m[k]}, 32'd1);
                        void'(q[k].pop_front());
                    end
                end
            end
            check("range_err_a", {31'b0, ra}, {31'b0, ecyc >= range_due});
            check("range_err_b", {31'b0, rb}, {31'b0, ecyc >= range_due});
        end
    end

    task automatic idle_ports();
        s_cs = '0; s_rd = '0; s_wr = '0;
        for (int p = 0; p < 2; p++) begin
            s_ad[p] = '0; s_be[p] = '0; s_wd[p] = '0;
        end
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input logic [12:0] ad,
                            input logic [3:0] be, input logic [31:0] wd);
        s_cs[p] = 1'b1; s_rd[p] = r; s_wr[p] = w;
        s_ad[p] = ad; s_be[p] = be; s_wd[p] = wd;
    endtask

    // Drives one cycle of stimulus and records what the memory should do with it.
    task automatic step();
        logic [31:0] exp;
        a1.chipselect = s_cs[0]; a1.read = s_rd[0]; a1.write = s_wr[0];
        a1.address = s_ad[0]; a1.byteenable = s_be[0]; a1.writedata = s_wd[0];
        b1.chipselect = s_cs[0]; b1.read = s_rd[0]; b1.write = s_wr[0];
        b1.address = s_ad[0]; b1.byteenable = s_be[0]; b1.writedata = s_wd[0];
        a2.chipselect = s_cs[1]; a2.read = s_rd[1]; a2.write = s_wr[1];
        a2.address = s_ad[1]; a2.byteenable = s_be[1]; a2.writedata = s_wd[1];
        b2.chipselect = s_cs[1]; b2.read = s_rd[1]; b2.write = s_wr[1];
        b2.address = s_ad[1]; b2.byteenable = s_be[1]; b2.writedata = s_wd[1];
        if (clken && !reset) begin
            for (int p = 0; p < 2; p++) begin
                if (s_cs[p] && s_rd[p] && !s_wr[p]) begin
                    exp = (s_ad[p] < DEPTH) ? model[s_ad[p]] : 32'd0;
                    q[p].push_back({32'(ecyc + 1), exp});
                    q[2+p].push_back({32'(ecyc + 2), exp});
                end
                if (s_cs[p] && (s_rd[p] || s_wr[p]) && s_ad[p] >= DEPTH && range_due > ecyc + 1)
                    range_due = ecyc + 1;
            end
            for (int p = 1; p >= 0; p--) begin
                if (s_cs[p] && s_wr[p] && s_ad[p] < DEPTH) begin
                    for (int i = 0; i < 4; i++)
                        if (s_be[p][i]) model[s_ad[p]][8*i +: 8] = s_wd[p][8*i +: 8];
                end
            end
        end
        @(posedge clk);
        #2;
    endtask

    function automatic logic [12:0] pick_addr();
        int sel = $urandom_range(0, 9);
        if (sel <= 6) return 13'($urandom_range(0, 63));
        if (sel == 7) return 13'd5119;
        if (sel == 8) return 13'd5120;
        return 13'($urandom_range(5121, 8191));
    endfunction

    task automatic clear_sb();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            last[k] = '0;
        end
        range_due = 32'h7fffffff;
    endtask

    initial begin
        clear_sb();
        idle_ports();
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_rdata[%0d]", k), rd_m[k], 32'd0);
            check($sformatf("reset_valid[%0d]", k), {31'b0, rv_m[k]}, 32'd0);
        end
        check("reset_range_a", {31'b0, ra}, 32'd0);
        check("reset_range_b", {31'b0, rb}, 32'd0);
        reset = 1'b0;

        for (int a = 0; a < 64; a += 2) begin
            idle_ports();
            set_port(0, 0, 1, 13'(a), 4'hF, $urandom);
            set_port(1, 0, 1, 13'(a + 1), 4'hF, $urandom);
            step();
        end
        idle_ports(); set_port(0, 0, 1, 13'd5119, 4'hF, $urandom); step();

        // Byte-lane merge
        idle_ports(); set_port(0, 0, 1, 13'h10, 4'hF, 32'h11223344); step();
        idle_ports(); set_port(0, 0, 1, 13'h10, 4'b0101, 32'hAABBCCDD); step();
        idle_ports(); set_port(1, 1, 0, 13'h10, 4'h0, 32'h0); step();

        // Same-address write collision
        idle_ports(); set_port(0, 0, 1, 13'h20, 4'hF, 32'h0); step();
        idle_ports();
        set_port(0, 0, 1, 13'h20, 4'b0001, 32'h000000FF);
        set_port(1, 0, 1, 13'h20, 4'b1101, 32'hFFFF0000);
        step();
        idle_ports(); set_port(0, 1, 0, 13'h20, 4'h0, 32'h0); set_port(1, 1, 0, 13'h20, 4'h0, 32'h0); step();

        // Mixed-port read-during-write
        idle_ports(); set_port(0, 0, 1, 13'h30, 4'hF, 32'h5); step();
        idle_ports(); set_port(0, 0, 1, 13'h30, 4'hF, 32'h9); set_port(1, 1, 0, 13'h30, 4'h0, 32'h0); step();
        idle_ports(); set_port(1, 1, 0, 13'h30, 4'h0, 32'h0); step();

        // Out-of-range accesses
        idle_ports(); set_port(0, 1, 0, 13'd5120, 4'h0, 32'h0); set_port(1, 0, 1, 13'd6000, 4'hF, 32'hDEADBEEF); step();
        idle_ports(); set_port(0, 1, 0, 13'd5119, 4'h0, 32'h0); set_port(1, 1, 1, 13'd63, 4'hF, 32'h12345678); step();

        for (int n = 0; n < 400; n++) begin
            idle_ports();
            clken = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) != 0)
                    set_port(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), pick_addr(),
                             4'($urandom_range(0, 15)), $urandom);
            end
            step();
        end
        clken = 1'b1;

        // Streaming reads with a two-cycle stall; port inputs during the stall are ignored
        for (int a = 1; a <= 3; a++) begin
            idle_ports(); set_port(0, 1, 0, 13'(a), 4'h0, 32'h0); step();
        end
        clken = 1'b0;
        for (int n = 0; n < 2; n++) begin
            idle_ports(); set_port(0, 0, 1, 13'd2, 4'hF, $urandom); set_port(1, 1, 0, 13'd3, 4'h0, 32'h0); step();
        end
        clken = 1'b1;
        idle_ports();
        for (int n = 0; n < 4; n++) step();

        // Reset right after a read accept drops it
        idle_ports(); set_port(0, 1, 0, 13'd5, 4'h0, 32'h0); set_port(1, 1, 0, 13'd6, 4'h0, 32'h0); step();
        reset = 1'b1;
        clear_sb();
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("midreset_rdata[%0d]", k), rd_m[k], 32'd0);
            check($sformatf("midreset_valid[%0d]", k), {31'b0, rv_m[k]}, 32'd0);
        end
        check("midreset_range_a", {31'b0, ra}, 32'd0);
        idle_ports();
        step();
        step();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) step();
        idle_ports(); set_port(0, 1, 0, 13'd5, 4'h0, 32'h0); set_port(1, 1, 0, 13'h30, 4'h0, 32'h0); step();

        idle_ports();
        for (int n = 0; n < 10; n++) begin
            if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) break;
            step();
        end
        for (int k = 0; k < 4; k++)
            if (q[k].size() != 0) check($sformatf("drain[%0d]", k), q[k].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
